// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS main controller (Moore FSM).              |
// | Optional: MC_CTRL_JAL_JR_EN enables jal / jr support.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IorD,
  output logic       MemWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       Illegal,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MRD    = 4'd4,
    S_MWB    = 4'd5,
    S_MWR    = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_ILL    = 4'd13
`ifdef MC_CTRL_JAL_JR_EN
    ,
    S_JAL    = 4'd14,
    S_RJR    = 4'd15
`endif
  } state_t;

  localparam logic [1:0] c_IMM_ADDIU = 2'd0;
  localparam logic [1:0] c_IMM_ORI   = 2'd1;
  localparam logic [1:0] c_IMM_LUI   = 2'd2;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_imm_kind;
  logic [1:0] w_imm_kind;

  // zero qualifies the PC write inside the datapath; nothing here depends on it
  logic w_unused_zero;
  assign w_unused_zero = zero;

  // The I-type flavour is latched leaving decode so S_IEXE stays a pure Moore state
  always_comb begin
    case (opcode)
      6'h0D:   w_imm_kind = c_IMM_ORI;
      6'h0F:   w_imm_kind = c_IMM_LUI;
      default: w_imm_kind = c_IMM_ADDIU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_imm_kind <= c_IMM_ADDIU;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_imm_kind <= w_imm_kind;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_INIT:  w_next = S_FETCH;
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h23, 6'h2B: w_next = S_MADDR;
`ifdef MC_CTRL_JAL_JR_EN
          6'h00:        w_next = (funct == 6'h08) ? S_RJR : S_REXE;
          6'h03:        w_next = S_JAL;
`else
          6'h00:        w_next = (funct == 6'h08) ? S_ILL : S_REXE;
`endif
          6'h04:        w_next = S_BRANCH;
          6'h02:        w_next = S_JUMP;
          6'h09, 6'h0D, 6'h0F: w_next = S_IEXE;
          default:      w_next = S_ILL;
        endcase
      end
      S_MADDR: w_next = (opcode == 6'h23) ? S_MRD : S_MWR;
      S_MRD:   w_next = S_MWB;
      S_REXE:  w_next = S_RWB;
      S_IEXE:  w_next = S_IWB;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr      = 1'b0;
    PCWrCond  = 1'b0;
    IorD      = 1'b0;
    MemWr     = 1'b0;
    IRWr      = 1'b0;
    RegWr     = 1'b0;
    RegDst    = 2'd0;
    MemtoReg  = 2'd0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'd0;
    ALUOp     = 3'd0;
    PCSource  = 2'd0;
    ExtOp     = 1'b0;
    Illegal   = 1'b0;
    InstrDone = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWr    = 1'b1;
        ALUSrcB = 2'd1;
        PCWr    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
      end
      S_MRD: IorD = 1'b1;
      S_MWB: begin
        RegWr     = 1'b1;
        MemtoReg  = 2'd1;
        InstrDone = 1'b1;
      end
      S_MWR: begin
        IorD      = 1'b1;
        MemWr     = 1'b1;
        InstrDone = 1'b1;
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'd2;
      end
      S_RWB: begin
        RegWr     = 1'b1;
        RegDst    = 2'd1;
        InstrDone = 1'b1;
      end
      S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (r_imm_kind)
          c_IMM_ORI: ALUOp = 3'd3;
          c_IMM_LUI: ALUOp = 3'd4;
          default: begin
            ALUOp = 3'd0;
            ExtOp = 1'b1;
          end
        endcase
      end
      S_IWB: begin
        RegWr     = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 3'd1;
        PCSource  = 2'd1;
        PCWrCond  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JUMP: begin
        PCSource  = 2'd2;
        PCWr      = 1'b1;
        InstrDone = 1'b1;
      end
`ifdef MC_CTRL_JAL_JR_EN
      S_JAL: begin
        PCSource  = 2'd2;
        PCWr      = 1'b1;
        RegWr     = 1'b1;
        RegDst    = 2'd2;
        MemtoReg  = 2'd2;
        InstrDone = 1'b1;
      end
      S_RJR: begin
        PCSource  = 2'd3;
        PCWr      = 1'b1;
        InstrDone = 1'b1;
      end
`endif
      S_ILL: begin
        Illegal   = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
